// File: rtl/week6_ex1_challenge_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// week6_ex1_challenge_sweep_ctrl
//
// Exhaustive sweep sequencer for the 7-input challenge circuit. On start it
// walks vec = 0..127 onto A..G. Each vector is held for SETTLE cycles and then
// sampled once. Over the sweep the block accumulates:
//   - the number of vectors that gave Y=1,
//   - a 16-bit MISR signature of the sampled Y stream,
//   - the lowest vector index that gave Y=1.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   begin a sweep (accepted in IDLE only)
//   abort        in   cancel a running sweep (ignored in IDLE)
//   A..G         out  challenge circuit inputs, A = vec[6] .. G = vec[0]
//   y_in         in   challenge circuit output Y
//   busy         out  sweep in progress (SETTLE, SAMPLE or DONE)
//   done         out  one-cycle pulse when a full sweep completes
//   ones_count   out  number of vectors with Y=1 (0..128)
//   signature    out  MISR over the sampled Y sequence
//   first_one    out  lowest vector index with Y=1
//   found        out  at least one Y=1 seen this sweep
//
// Parameter
//   SETTLE       cycles each vector is held before sampling, 1..15
//
// States
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start, results from the last sweep held
//   SETTLE | vec applied to A..G, settle_cnt counting hold cycles
//   SAMPLE | y_in sampled, results updated, vec advanced at closing edge
//   DONE   | sweep finished, done pulse for this single cycle
// ---------------------------------------------------------------------------
module week6_ex1_challenge_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  output logic        F,
  output logic        G,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ones_count,
  output logic [15:0] signature,
  output logic [6:0]  first_one,
  output logic        found
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [6:0]  VEC_LAST    = 7'd127;
  localparam logic [15:0] MISR_POLY   = 16'h1021;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [6:0]  vec;
  logic [3:0]  settle_cnt;
  logic [15:0] signature_nxt;

  logic start_accept;
  logic sample_en;
  logic vec_advance;

  // A start is only honoured from IDLE; abort in IDLE has no meaning, so a
  // simultaneous start+abort there is simply a start.
  assign start_accept = (state == ST_IDLE) && start;

  // Abort cancels the pending sample as well as the transition out of SAMPLE,
  // so a partial result never includes the vector that was in flight.
  assign sample_en   = (state == ST_SAMPLE) && !abort;
  assign vec_advance = sample_en && (vec != VEC_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (vec == VEC_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Vector and settle counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= 7'd0;
      settle_cnt <= 4'd0;
    end else if (start_accept) begin
      vec        <= 7'd0;
      settle_cnt <= 4'd0;
    end else if ((state == ST_SETTLE) && !abort) begin
      settle_cnt <= settle_cnt + 4'd1;
    end else if (vec_advance) begin
      vec        <= vec + 7'd1;
      settle_cnt <= 4'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Result accumulation
  // -------------------------------------------------------------------------
  // CCITT-polynomial MISR with the sampled Y folded into bit 0.
  always_comb begin
    signature_nxt = {signature[14:0], 1'b0}
                  ^ (signature[15] ? MISR_POLY : 16'h0000)
                  ^ {15'b0, y_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_count <= 8'd0;
      signature  <= 16'h0000;
      first_one  <= 7'd0;
      found      <= 1'b0;
    end else if (start_accept) begin
      ones_count <= 8'd0;
      signature  <= 16'h0000;
      first_one  <= 7'd0;
      found      <= 1'b0;
    end else if (sample_en) begin
      // At most 128 increments per sweep, so 8 bits never wrap.
      ones_count <= ones_count + {7'd0, y_in};
      signature  <= signature_nxt;
      if (y_in && !found) begin
        first_one <= vec;
        found     <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign {A, B, C, D, E, F, G} = vec;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: doc/week6_ex1_challenge_sweep_ctrl.md
# week6_ex1_challenge_sweep_ctrl

Sequencer that exhaustively drives the 7-input challenge circuit (inputs A–G, output Y) through all 128 input combinations. It waits a programmable settle time per vector, samples Y, and accumulates a ones count, a 16-bit MISR signature and the first minterm where Y=1. It sits between a test/host start-done handshake and the combinational challenge circuit instance, and owns that circuit's inputs exclusively.

## Interface
- `SETTLE`, default 2: cycles each vector is held before Y is sampled; legal range 1–15.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a sweep; accepted only in IDLE.
- `abort`  in  1: cancel a running sweep.
- `A`,`B`,`C`,`D`,`E`,`F`,`G`  out  1 each: drive the challenge circuit; A = vec[6] … G = vec[0].
- `y_in`  in  1: challenge circuit output Y.
- `busy`  out  1: high from start acceptance until DONE exits or abort.
- `done`  out  1: one-cycle pulse when a full sweep completes.
- `ones_count`  out  8: number of vectors with Y=1 (0–128).
- `signature`  out  16: MISR over the sampled Y sequence.
- `first_one`  out  7: lowest vector index where Y=1.
- `found`  out  1: at least one Y=1 seen this sweep.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Internal 7-bit vec and 4-bit settle_cnt.
- IDLE: busy=0. On start=1, the next state is SETTLE. On entry: vec=0, settle_cnt=0, ones_count=0, signature=0, first_one=0, found=0.
- SETTLE: A–G = vec. settle_cnt increments each cycle. When settle_cnt==SETTLE-1, the next state is SAMPLE.
- SAMPLE: y_in is sampled in this cycle and the updates take effect at its closing edge:
  - ones_count += y_in.
  - signature = {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ {15'b0,y_in}.
  - If y_in=1 and found=0: first_one=vec, found=1.
  - If vec==127, the next state is DONE. Otherwise vec+1, settle_cnt=0, and the next state is SETTLE.
- DONE: done=1 for exactly this cycle, busy=1. The next state is IDLE. Results hold until the next accepted start or reset.
- A–G hold the last vec in IDLE/DONE. They are 0 after reset and 0 from start acceptance onward.
- vec never wraps within a sweep. Reaching 127 terminates the sweep.
- ones_count is 8 bits so the value 128 is representable. It never saturates or wraps.
- start while busy: ignored, with no restart and no effect on counters.
- abort (any non-IDLE state): the next state is IDLE, busy=0, and there is no done pulse. Partial results hold. abort has priority over the SAMPLE→DONE transition. abort in IDLE is ignored.
- start and abort together in IDLE: the start is accepted.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, A–G=0, ones_count=0, signature=0, first_one=0, found=0.
- The start is sampled at edge T0. Cycles T0+1…T0+SETTLE are the SETTLE state and T0+SETTLE+1 is the SAMPLE state for vec=0.
- Each vector occupies SETTLE+1 cycles. The vector is applied for at least SETTLE full cycles before sampling.
- done is high in cycle T0+1+128·(SETTLE+1). For SETTLE=2, that is T0+385. The results are final in the same cycle.
- busy rises in cycle T0+1 and falls in the cycle after done.
- A new start is accepted in the cycle after done at the earliest.
- Reset asserted mid-sweep: everything returns to reset values at once, and no done is issued.

## Test plan
- y_in tied 0, SETTLE=2, pulse start → done at T0+385; ones_count=0, signature=16'h0000, found=0, first_one=0.
- y_in = (vec==7'h55) → ones_count=1, first_one=7'h55, found=1; signature equals the bench MISR model.
- y_in tied 1 → ones_count=128 (8'h80), first_one=0, found=1; signature matches the model.
- Behavioral challenge-circuit model driven by A–G → ones_count, first_one and signature match an offline 128-entry evaluation; each vector is held ≥SETTLE cycles before its sample.
- abort at vec=40 → busy falls next cycle, no done pulse, ones_count holds its partial value; a start pulsed during the sweep is ignored (done timing unchanged).
- rst asserted at vec=90, released, then a new start → outputs are 0 immediately on reset; the next sweep completes normally with done at T0+385.
